// File: rtl/debug_scratch_master.sv
// Word-level read/write sequencer for the byte-wide debug RAM scratch port.
// Each command walks the byte lanes in order, then returns one response.
module debug_scratch_master #(
  parameter int unsigned INDEX     = 8,
  parameter int unsigned WIDTH_LOG = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmdValid_i,
  output logic                          cmdReady_o,
  input  logic                          cmdWrite_i,
  input  logic [INDEX-1:0]              cmdIndex_i,
  input  logic [(8<<WIDTH_LOG)-1:0]     cmdData_i,
  input  logic [(1<<WIDTH_LOG)-1:0]     cmdByteEn_i,
  output logic                          rspValid_o,
  input  logic                          rspReady_i,
  output logic [(8<<WIDTH_LOG)-1:0]     rspData_o,
  output logic                          rspWrite_o,
  output logic [INDEX+WIDTH_LOG-1:0]    dataScratchAddr_o,
  output logic [7:0]                    dataScratchWrData_o,
  output logic                          dataScratchWrEn_o,
  input  logic [7:0]                    dataScratchRdData_i
);

  localparam int unsigned DW = 8 << WIDTH_LOG;
  localparam int unsigned NB = 1 << WIDTH_LOG;
  localparam int unsigned LW = WIDTH_LOG;
  localparam int unsigned AW = INDEX + WIDTH_LOG;

  typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

  state_e          state_q;
  logic [LW-1:0]   lane_q;
  logic            write_q;
  logic [INDEX-1:0] index_q;
  logic [DW-1:0]   data_q;
  logic [NB-1:0]   byte_en_q;
  logic [DW-1:0]   acc_q;

  logic [AW-1:0]   addr_q;
  logic [7:0]      wr_data_q;
  logic            wr_en_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;
  logic            rsp_write_q;

  logic [LW-1:0]   lane_nxt;
  logic [DW-1:0]   acc_nxt;
  logic            nxt_en;

  // Accumulator with the byte of the lane currently on the port merged in.
  always_comb begin
    lane_nxt = lane_q + 1'b1;
    nxt_en   = write_q & byte_en_q[lane_nxt];
    acc_nxt  = acc_q;
    acc_nxt[8*int'(lane_q) +: 8] = dataScratchRdData_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      lane_q      <= '0;
      write_q     <= 1'b0;
      index_q     <= '0;
      data_q      <= '0;
      byte_en_q   <= '0;
      acc_q       <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmdValid_i) begin
            state_q   <= StXfer;
            write_q   <= cmdWrite_i;
            index_q   <= cmdIndex_i;
            data_q    <= cmdData_i;
            byte_en_q <= cmdByteEn_i;
            lane_q    <= '0;
            acc_q     <= '0;
            // Lane 0 goes out in the first XFER cycle.
            addr_q    <= {LW'(0), cmdIndex_i};
            wr_en_q   <= cmdWrite_i & cmdByteEn_i[0];
            wr_data_q <= (cmdWrite_i & cmdByteEn_i[0]) ? cmdData_i[7:0] : 8'h00;
          end
        end
        StXfer: begin
          lane_q <= lane_nxt;
          if (!write_q) acc_q <= acc_nxt;
          if (lane_q == LW'(NB - 1)) begin
            state_q     <= StResp;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= write_q ? '0 : acc_nxt;
            rsp_write_q <= write_q;
          end else begin
            addr_q    <= {lane_nxt, index_q};
            wr_en_q   <= nxt_en;
            wr_data_q <= nxt_en ? data_q[8*int'(lane_nxt) +: 8] : 8'h00;
          end
        end
        StResp: begin
          if (rspReady_i) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_write_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmdReady_o          = (state_q == StIdle);
  assign rspValid_o          = rsp_valid_q;
  assign rspData_o           = rsp_data_q;
  assign rspWrite_o          = rsp_write_q;
  assign dataScratchAddr_o   = addr_q;
  assign dataScratchWrData_o = wr_data_q;
  assign dataScratchWrEn_o   = wr_en_q;

endmodule

// File: tb/tb_debug_scratch_master.sv
// Randomised bench for debug_scratch_master: a RAM behind the scratch port and a
// per-cycle timeline model of the command/response behaviour.
module tb_debug_scratch_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmdValid_i = 1'b0;
  logic        cmdReady_o;
  logic        cmdWrite_i = 1'b0;
  logic [7:0]  cmdIndex_i = '0;
  logic [63:0] cmdData_i = '0;
  logic [7:0]  cmdByteEn_i = '0;
  logic        rspValid_o;
  logic        rspReady_i = 1'b0;
  logic [63:0] rspData_o;
  logic        rspWrite_o;
  logic [10:0] dataScratchAddr_o;
  logic [7:0]  dataScratchWrData_o;
  logic        dataScratchWrEn_o;
  logic [7:0]  dataScratchRdData_i;

  debug_scratch_master #(.INDEX(8), .WIDTH_LOG(3)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmdValid_i          (cmdValid_i),
    .cmdReady_o          (cmdReady_o),
    .cmdWrite_i          (cmdWrite_i),
    .cmdIndex_i          (cmdIndex_i),
    .cmdData_i           (cmdData_i),
    .cmdByteEn_i         (cmdByteEn_i),
    .rspValid_o          (rspValid_o),
    .rspReady_i          (rspReady_i),
    .rspData_o           (rspData_o),
    .rspWrite_o          (rspWrite_o),
    .dataScratchAddr_o   (dataScratchAddr_o),
    .dataScratchWrData_o (dataScratchWrData_o),
    .dataScratchWrEn_o   (dataScratchWrEn_o),
    .dataScratchRdData_i (dataScratchRdData_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Byte-addressed RAM behind the scratch port, read combinationally.
  logic [7:0] ram [0:2047];
  initial for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
  always @(posedge clk) if (dataScratchWrEn_o) ram[dataScratchAddr_o] <= dataScratchWrData_o;
  assign dataScratchRdData_i = ram[dataScratchAddr_o];

  // Reference word memory, updated once per accepted write command.
  logic [63:0] ref_mem [0:255];
  bit          known [0:255];
  initial for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; known[i] = 1'b1; end

  // Timeline model: phase 1..8 = lane phase-1 on the port, phase 9 = response.
  bit          started = 0;
  bit          m_busy = 0;
  int          m_phase = 0;
  logic        m_write;
  logic [7:0]  m_idx;
  logic [63:0] m_data;
  logic [7:0]  m_en;
  logic [63:0] m_exp;
  bit          m_known;

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      if (m_busy && m_write && m_phase <= 8) known[m_idx] = 1'b0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (cmdValid_i) begin
        m_busy = 1; m_phase = 1;
        m_write = cmdWrite_i; m_idx = cmdIndex_i; m_data = cmdData_i; m_en = cmdByteEn_i;
        if (cmdWrite_i) begin
          for (int b = 0; b < 8; b++)
            if (cmdByteEn_i[b]) ref_mem[cmdIndex_i][8*b +: 8] = cmdData_i[8*b +: 8];
          if (cmdByteEn_i == 8'hFF) known[cmdIndex_i] = 1'b1;
          m_exp = '0; m_known = 1'b1;
        end else begin
          m_exp = ref_mem[cmdIndex_i]; m_known = known[cmdIndex_i];
        end
      end
    end else if (m_phase < 9) begin
      m_phase++;
    end else if (rspReady_i) begin
      m_busy = 0;
    end
  end

  logic [10:0] e_addr;
  logic [7:0]  e_wd;
  logic        e_en, e_rv, e_rw;
  logic [63:0] e_rd;
  int          e_k;

  always @(negedge clk) if (started) begin
    e_addr = '0; e_wd = '0; e_en = 0; e_rv = 0; e_rw = 0; e_rd = '0;
    if (m_busy && m_phase <= 8) begin
      e_k    = m_phase - 1;
      e_addr = 11'(e_k * 256 + int'(m_idx));
      e_en   = m_write & m_en[e_k];
      e_wd   = e_en ? m_data[8*e_k +: 8] : 8'h00;
    end else if (m_busy) begin
      e_rv = 1; e_rw = m_write; e_rd = m_exp;
    end
    chk("cmdReady", 64'(cmdReady_o), 64'(!m_busy));
    chk("addr", 64'(dataScratchAddr_o), 64'(e_addr));
    chk("wrEn", 64'(dataScratchWrEn_o), 64'(e_en));
    chk("wrData", 64'(dataScratchWrData_o), 64'(e_wd));
    chk("rspValid", 64'(rspValid_o), 64'(e_rv));
    chk("rspWrite", 64'(rspWrite_o), 64'(e_rw));
    if (!(e_rv && !m_write && !m_known)) chk("rspData", rspData_o, e_rd);
  end

  // Per-cycle record of the last command, index = cycles after the handshake.
  logic [10:0] rec_addr [0:21];
  logic [7:0]  rec_wd [0:21];
  logic        rec_en [0:21];
  int          rec_lat;
  logic [63:0] rec_rsp;
  logic        rec_rw;

  task automatic junk_fields();
    cmdWrite_i = 1'($urandom); cmdIndex_i = 8'($urandom);
    cmdData_i = {$urandom, $urandom}; cmdByteEn_i = 8'($urandom);
  endtask

  // Called with inputs settled just after a rising edge.
  task automatic run_cmd(input logic w, input logic [7:0] idx, input logic [63:0] d,
                         input logic [7:0] en, input int rdy_delay, input logic junk);
    bit hs = 0;
    int c;
    cmdValid_i = 1; cmdWrite_i = w; cmdIndex_i = idx; cmdData_i = d; cmdByteEn_i = en;
    rspReady_i = 0;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk); hs = cmdReady_o;
      @(posedge clk); #2;
    end
    if (!hs) begin chk("handshake timeout", 0, 1); cmdValid_i = 0; return; end
    cmdValid_i = junk;
    if (junk) junk_fields();
    for (c = 1; c <= 20; c++) begin
      @(negedge clk);
      rec_addr[c] = dataScratchAddr_o; rec_wd[c] = dataScratchWrData_o;
      rec_en[c] = dataScratchWrEn_o;
      if (rspValid_o) break;
      @(posedge clk); #2;
      if (junk) junk_fields();
    end
    rec_lat = c; rec_rsp = rspData_o; rec_rw = rspWrite_o;
    if (c > 20) begin chk("response timeout", 0, 1); cmdValid_i = 0; return; end
    for (int i = 0; i < rdy_delay; i++) begin
      @(posedge clk); #2;
      if (junk) junk_fields();
    end
    rspReady_i = 1;
    @(posedge clk); #2;
    rspReady_i = 0; cmdValid_i = 0;
  endtask

  logic [63:0] held;
  logic [7:0]  ridx;
  int          pick;

  initial begin
    #1;
    repeat (2) @(posedge clk);
    #2; reset = 0;
    @(negedge clk);
    chk("reset cmdReady", 64'(cmdReady_o), 1);
    chk("reset rspValid", 64'(rspValid_o), 0);
    chk("reset addr", 64'(dataScratchAddr_o), 0);
    @(posedge clk); #2;

    // Full write
    run_cmd(1, 8'h05, 64'h0807060504030201, 8'hFF, 0, 0);
    chk("full write latency", 64'(rec_lat), 9);
    for (int k = 0; k < 8; k++) begin
      chk("full write en", 64'(rec_en[k+1]), 1);
      chk("full write addr", 64'(rec_addr[k+1]), 64'(k * 256 + 5));
      chk("full write data", 64'(rec_wd[k+1]), 64'(k + 1));
    end
    chk("full write rspData", rec_rsp, 0);
    chk("full write rspWrite", 64'(rec_rw), 1);

    // Readback
    run_cmd(0, 8'h05, 64'h0, 8'hFF, 0, 0);
    chk("readback data", rec_rsp, 64'h0807060504030201);
    chk("readback rspWrite", 64'(rec_rw), 0);
    for (int k = 1; k <= 8; k++) chk("readback wrEn", 64'(rec_en[k]), 0);

    // Partial write
    run_cmd(1, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0);
    chk("partial latency", 64'(rec_lat), 9);
    for (int k = 0; k < 8; k++) chk("partial en", 64'(rec_en[k+1]), (k < 4) ? 1 : 0);
    run_cmd(0, 8'h05, 64'h0, 8'h00, 0, 0);
    chk("partial readback", rec_rsp, 64'h08070605FFFFFFFF);

    // Response backpressure with cmdValid held high
    fork
      run_cmd(0, 8'h05, 64'h0, 8'h00, 5, 1);
      begin
        wait (rspValid_o === 1'b1 || $time > 64'd100000);
        @(negedge clk); held = rspData_o;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("backpressure held", rspData_o, held);
          chk("backpressure ready", 64'(cmdReady_o), 0);
          chk("backpressure wrEn", 64'(dataScratchWrEn_o), 0);
        end
      end
    join
    chk("backpressure data", rec_rsp, 64'h08070605FFFFFFFF);
    @(negedge clk);
    chk("cmdReady after rsp", 64'(cmdReady_o), 1);
    @(posedge clk); #2;

    // Reset during lane 3 of a write
    cmdValid_i = 1; cmdWrite_i = 1; cmdIndex_i = 8'h33;
    cmdData_i = 64'h1111_2222_3333_4444; cmdByteEn_i = 8'hFF;
    @(posedge clk); #2; cmdValid_i = 0;
    repeat (3) @(posedge clk);
    #2; reset = 1;
    @(negedge clk);
    chk("lane3 wrEn", 64'(dataScratchWrEn_o), 1);
    chk("lane3 addr", 64'(dataScratchAddr_o), 64'h333);
    @(posedge clk); #2; reset = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort wrEn", 64'(dataScratchWrEn_o), 0);
      chk("abort rspValid", 64'(rspValid_o), 0);
      chk("abort cmdReady", 64'(cmdReady_o), 1);
    end
    @(posedge clk); #2;

    // Top index and its neighbour
    run_cmd(1, 8'hFF, 64'hDEADBEEFCAFEF00D, 8'hFF, 1, 0);
    chk("top lane7 addr", 64'(rec_addr[8]), 64'h7FF);
    run_cmd(0, 8'hFF, 64'h0, 8'h00, 2, 0);
    chk("top readback", rec_rsp, 64'hDEADBEEFCAFEF00D);
    run_cmd(0, 8'h00, 64'h0, 8'h00, 0, 0);
    chk("idx0 unchanged", rec_rsp, 64'h0);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      pick = int'($urandom_range(0, 4));
      case (pick)
        0: ridx = 8'h05;
        1: ridx = 8'hFF;
        2: ridx = 8'h00;
        3: ridx = 8'h33;
        default: ridx = 8'($urandom);
      endcase
      run_cmd(1'($urandom), ridx, {$urandom, $urandom}, 8'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
      if (($urandom % 4) == 0) begin @(posedge clk); #2; end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debug_scratch_master.md
# debug_scratch_master

Sequencing initiator for the byte-wide debug scratch port of the debug data RAM. It accepts word-level read and write commands from the debug host logic over a valid/ready channel. Each command becomes eight byte accesses on the RAM's scratch port (`{byte lane, word index}` address, 8-bit write data, write enable, combinational 8-bit read data). Read bytes are reassembled into a 64-bit word, and every command returns one response. The block sits between the debug command decoder and the RAM's scratch port, which has write priority over the core write port inside the RAM.

## Interface
Parameters:
- `INDEX`, default `DEBUG_DATA_RAM_LOG (8): word-index width; must match the RAM's INDEX.
- `WIDTH_LOG`, default `DEBUG_DATA_RAM_WIDTH_LOG (3): log2 of bytes per word. Word width is 8<<WIDTH_LOG = 64.

Ports. Single clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `cmdValid_i`  in  1  command present
- `cmdReady_o`  out  1  command accepted when high with cmdValid_i at rising edge
- `cmdWrite_i`  in  1  1 = write, 0 = read
- `cmdIndex_i`  in  INDEX  word index
- `cmdData_i`  in  64  write data; byte b = bits [8b+7:8b]
- `cmdByteEn_i`  in  8  per-byte write enable; ignored for reads
- `rspValid_o`  out  1  response present
- `rspReady_i`  in  1  response consumed when high with rspValid_o at rising edge
- `rspData_o`  out  64  read word; all-zero for write responses
- `rspWrite_o`  out  1  echo of command type
- `dataScratchAddr_o`  out  INDEX+WIDTH_LOG  `{byte lane, word index}` to the RAM
- `dataScratchWrData_o`  out  8  byte write data
- `dataScratchWrEn_o`  out  1  byte write strobe
- `dataScratchRdData_i`  in  8  combinational RAM read byte for the current address

## Operation
States: IDLE, XFER, RESP.
- **IDLE.**
  - `cmdReady_o`=1; all scratch outputs are 0.
  - On handshake, latch write/index/data/byteEn, clear the 3-bit lane counter, clear the read accumulator, and go to XFER.
- **XFER.** One byte lane per cycle, lane k = 0..7.
  - `dataScratchAddr_o` = {k, index}.
  - Write command: `dataScratchWrData_o` = data[8k+7:8k] and `dataScratchWrEn_o` = byteEn[k]. Disabled lanes still take their cycle, with WrEn=0 and WrData=0.
  - Read command: `dataScratchWrEn_o`=0; at the clock edge ending lane k, `dataScratchRdData_i` is captured into accumulator[8k+7:8k].
  - After lane 7, go to RESP. The counter wraps to 0 and is not reused.
- **RESP.**
  - `rspValid_o`=1. `rspData_o` = accumulator for reads, 0 for writes. `rspWrite_o` = latched type.
  - Outputs are held stable until the `rspReady_i` handshake, then go to IDLE.
- `cmdReady_o`=0 in XFER and RESP. `cmdValid_i` is ignored there, and no command is queued.
- All scratch-port outputs and response outputs are registered. Only `cmdReady_o` is a decode of the state register.
- The index has no bounds check; all 2^INDEX values are legal. Index 2^INDEX−1 with lane 7 gives address all-ones.

## Timing
- Command handshake at edge T0 → lane k is driven during cycle T0+1+k → `rspValid_o` rises in cycle T0+9.
- With `rspReady_i` held high, the response handshake is at edge T0+9, `cmdReady_o`=1 in cycle T0+10, and the minimum command-to-command spacing is 10 cycles.
- Read data must be valid combinationally in the same cycle as its address. The block adds no wait states.
- Reset values, during the reset cycle and after it:
  - state IDLE, `cmdReady_o`=1
  - `rspValid_o`=0, `rspData_o`=0, `rspWrite_o`=0
  - `dataScratchAddr_o`=0, `dataScratchWrData_o`=0, `dataScratchWrEn_o`=0
  - counter 0, accumulator 0
- Reset in mid-XFER or RESP aborts the command:
  - no further strobes and no response
  - bytes already written remain written; the RAM itself is also reset by the same signal.
- Reset and a command handshake in the same cycle: the command is dropped.

## Test plan
- **Full write.** After reset, write idx 0x05, data 0x0807060504030201, byteEn 0xFF.
  - Required: WrEn=1 for 8 consecutive cycles, addr 0x005, 0x105, …, 0x705, WrData 01..08.
  - Required: `rspValid_o` in cycle T0+9 with rspData=0 and rspWrite=1.
- **Readback.** Read idx 0x05 against the RAM model → rspData=0x0807060504030201, rspWrite=0, WrEn never asserted.
- **Partial write.** Write idx 0x05, data 0xFFFFFFFFFFFFFFFF, byteEn 0x0F.
  - Required: WrEn high only in lanes 0–3, and still 9 cycles to the response.
  - Required: readback gives 0x08070605FFFFFFFF.
- **Response backpressure.** Hold `rspReady_i` low for 5 cycles while asserting `cmdValid_i` → rspValid/rspData held constant, cmdReady=0, no scratch activity; handshake on the 6th edge, cmdReady=1 in the next cycle.
- **Reset mid-write.** Assert reset during lane 3 of a write → WrEn=0 from the next cycle, no response, cmdReady=1 after reset.
- **Top index.** Write then read idx 0xFF, data 0xDEADBEEFCAFEF00D → lane 7 addr=0x7FF, readback matches, and the adjacent idx 0x00 is unchanged.
